// File: rtl/mux2_arbiter_if.sv
// -----------------------------------------------------------------------------
// mux2_arbiter_if
//
// Purpose:
//   One valid/ready packet stream (beat payload plus end-of-packet flag).
//   The arbiter uses three of these: two upstream requesters and one
//   downstream output.
//
// Parameters:
//   WIDTH  payload width in bits (default 8)
//
// Signals:
//   valid  producer offers a beat
//   ready  consumer takes the beat this cycle when valid is also high
//   data   beat payload
//   last   beat is the final beat of its packet
//
// Modports:
//   master  producer side (drives valid/data/last, samples ready)
//   slave   consumer side (samples valid/data/last, drives ready)
// -----------------------------------------------------------------------------
interface mux2_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;
    logic             last;

    modport master (
        output valid,
        output data,
        output last,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  last,
        output ready
    );
endinterface

// File: rtl/mux2_arbiter.sv
// -----------------------------------------------------------------------------
// mux2_arbiter
//
// Purpose:
//   Two-input packet multiplexer with a one-entry registered output stage.
//   A requester wins the output for a whole packet; the grant is released
//   when its last beat is accepted. Ties in IDLE are resolved round-robin
//   (the requester not granted most recently wins; after reset requester 1
//   is favoured). Arbitration in IDLE is combinational so the first beat of
//   a packet is accepted in the cycle it is offered, and back-to-back packets
//   from both requesters alternate without an idle cycle.
//
// Build option:
//   MUX2_ARBITER_FIXED_PRIO_EN  when defined, ties always go to requester 1
//                               and no priority pointer is built.
//
// Parameters:
//   WIDTH   payload width (default 8)
//
// Ports:
//   clk     clock, rising edge
//   rst_n   asynchronous active-low reset
//   in1     requester 1 stream (slave):  valid, data, last in; ready out
//   in2     requester 2 stream (slave):  valid, data, last in; ready out
//   out     output stream (master): registered valid, data, last; ready in
//   select  current mux select, 0 = requester 1, 1 = requester 2
//           (meaningful while busy is high or in an accepting cycle)
//   busy    high while a multi-beat packet grant is held
// -----------------------------------------------------------------------------
module mux2_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mux2_arbiter_if.slave        in1,
    mux2_arbiter_if.slave        in2,
    mux2_arbiter_if.master       out,
    output logic                 select,
    output logic                 busy
);

    // -------------------------------------------------------------------------
    // State encoding
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT1 = 2'd1,
        GNT2 = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    // -------------------------------------------------------------------------
    // Requesters gathered into index-addressable vectors (index 0 = in1,
    // index 1 = in2) so the grant logic can be written once for both.
    // -------------------------------------------------------------------------
    logic [1:0]       req_valid;
    logic [1:0]       req_last;
    logic [1:0]       req_ready;
    logic [WIDTH-1:0] req_data [2];

    assign req_valid   = {in2.valid, in1.valid};
    assign req_last    = {in2.last,  in1.last};
    assign req_data[0] = in1.data;
    assign req_data[1] = in2.data;

    assign in1.ready = req_ready[0];
    assign in2.ready = req_ready[1];

    // -------------------------------------------------------------------------
    // Output stage registers
    // -------------------------------------------------------------------------
    logic             out_valid_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic             out_last_reg;

    // Select seen by the outside world when nothing is being granted.
    logic             sel_reg;

    // -------------------------------------------------------------------------
    // Grant decode
    // -------------------------------------------------------------------------
    logic             grant_active;  // some requester currently owns (or wins) the mux
    logic             grant_idx;     // which one: 0 = in1, 1 = in2
    logic             tie_pick;      // winner when both request in IDLE
    logic             can_load;      // output register can take a beat this cycle
    logic             accept;        // a beat moves from the granted input this cycle
    logic             accept_last;   // ...and it closes the packet
    logic [WIDTH-1:0] accept_data;

    // The output register is a one-entry pipeline stage: it can load when it
    // is empty or when its current beat leaves on this same edge.
    assign can_load = !out_valid_reg || out.ready;

`ifdef MUX2_ARBITER_FIXED_PRIO_EN
    // Fixed priority: requester 1 always wins a tie, no pointer state.
    assign tie_pick = 1'b0;
`else
    // Round-robin pointer: 0 favours requester 1, 1 favours requester 2.
    // Moves only when a packet completes, pointing away from its owner.
    logic prio_reg;
    logic prio_next;

    always_comb begin
        prio_next = prio_reg;
        if (accept && accept_last) begin
            prio_next = ~grant_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_reg <= 1'b0;
        end else begin
            prio_reg <= prio_next;
        end
    end

    assign tie_pick = prio_reg;
`endif

    // Grant owner: locked while in GNTn, decided combinationally in IDLE so
    // the first beat of a packet is taken without a bubble.
    always_comb begin
        grant_active = 1'b0;
        grant_idx    = 1'b0;
        unique case (state_reg)
            IDLE: begin
                grant_active = |req_valid;
                if (req_valid == 2'b11) begin
                    grant_idx = tie_pick;
                end else begin
                    // Single requester (or none, where the value is unused).
                    grant_idx = req_valid[1];
                end
            end
            GNT1: begin
                grant_active = 1'b1;
                grant_idx    = 1'b0;
            end
            GNT2: begin
                grant_active = 1'b1;
                grant_idx    = 1'b1;
            end
            default: begin
                grant_active = 1'b0;
                grant_idx    = 1'b0;
            end
        endcase
    end

    // Only the granted requester ever sees ready. Ready is forced low while
    // reset is asserted so no beat can slip in during reset.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready[gi] = rst_n & grant_active & can_load
                                 & (grant_idx == 1'(gi));
        end
    endgenerate

    assign accept      = req_ready[grant_idx] & req_valid[grant_idx];
    assign accept_last = req_last[grant_idx];
    assign accept_data = req_data[grant_idx];

    // -------------------------------------------------------------------------
    // FSM: state register + next-state logic
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                // A one-beat packet opens and closes on the same edge, so the
                // FSM stays in IDLE and re-arbitrates next cycle.
                if (accept && !accept_last) begin
                    state_next = grant_idx ? GNT2 : GNT1;
                end
            end
            GNT1, GNT2: begin
                // A requester that drops valid mid-packet keeps the grant.
                if (accept && accept_last) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_last_reg  <= 1'b0;
        end else if (accept) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= accept_data;
            out_last_reg  <= accept_last;
        end else if (out.ready) begin
            // Beat leaves with nothing behind it; payload is left as is.
            out_valid_reg <= 1'b0;
        end
    end

    assign out.valid = out_valid_reg;
    assign out.data  = out_data_reg;
    assign out.last  = out_last_reg;

    // -------------------------------------------------------------------------
    // Select / busy
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_reg <= 1'b0;
        end else if (accept) begin
            sel_reg <= grant_idx;
        end
    end

    // Live grant while a packet is held or a beat is being accepted;
    // otherwise the last granted requester is shown.
    assign select = (accept || (state_reg != IDLE)) ? grant_idx : sel_reg;
    assign busy   = (state_reg != IDLE);

endmodule

// File: tb/tb_mux2_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux2_arbiter
//
// Directed vector table (reset state, round-robin tie, packet lock), hand
// sequences for backpressure and reset mid-packet, then randomized traffic
// checked against a packet-level reference model (owner / last-owner / one
// entry output queue). Build with MUX2_ARBITER_FIXED_PRIO_EN to check the
// fixed-priority variant; expectations follow the macro.
// -----------------------------------------------------------------------------
module tb_mux2_arbiter;

    localparam int WIDTH = 8;
`ifdef MUX2_ARBITER_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic select;
    logic busy;

    mux2_arbiter_if #(.WIDTH(WIDTH)) in1_if ();
    mux2_arbiter_if #(.WIDTH(WIDTH)) in2_if ();
    mux2_arbiter_if #(.WIDTH(WIDTH)) out_if ();

    mux2_arbiter #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .in1    (in1_if),
        .in2    (in2_if),
        .out    (out_if),
        .select (select),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v1, input logic [7:0] d1, input logic l1,
                         input logic v2, input logic [7:0] d2, input logic l2,
                         input logic ordy);
        in1_if.valid = v1;
        in1_if.data  = d1;
        in1_if.last  = l1;
        in2_if.valid = v2;
        in2_if.data  = d2;
        in2_if.last  = l2;
        out_if.ready = ordy;
    endtask

    typedef struct {
        logic       v1;
        logic [7:0] d1;
        logic       l1;
        logic       v2;
        logic [7:0] d2;
        logic       l2;
        logic       ordy;
        logic       r1;
        logic       r2;
        logic       sel;
        logic       bsy;
        logic       ov;
        logic [7:0] od;
        logic       ol;
    } vec_t;

    function automatic vec_t mk(logic v1, logic [7:0] d1, logic l1,
                                logic v2, logic [7:0] d2, logic l2, logic ordy,
                                logic r1, logic r2, logic sel, logic bsy,
                                logic ov, logic [7:0] od, logic ol);
        vec_t v;
        v.v1 = v1; v.d1 = d1; v.l1 = l1;
        v.v2 = v2; v.d2 = d2; v.l2 = l2; v.ordy = ordy;
        v.r1 = r1; v.r2 = r2; v.sel = sel; v.bsy = bsy;
        v.ov = ov; v.od = od; v.ol = ol;
        return v;
    endfunction

    // Watchdog: the run is fixed-length, this only guards against a stall.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    // Reference model state for the random phase
    int         owner;       // 0 = no packet held, else requester number
    int         last_owner;  // requester that completed the most recent packet
    int         last_sel;    // select shown when nothing is granted
    logic [8:0] mq [$];      // {last, data} of beat sitting in the output stage
    logic       svld [1:2];
    logic [7:0] sdat [1:2];
    logic       slst [1:2];
    int         srem [1:2];

    vec_t tbl [10];

    initial begin
        int         g;
        int         accepts;
        logic       space;
        logic       acc;
        logic       e_r1;
        logic       e_r2;
        logic       ordy;
        logic [8:0] head;

        // ---------------------------------------------------------------------
        // Reset state (inputs valid to show ready is held low during reset)
        // ---------------------------------------------------------------------
        drive(1, 8'h01, 1, 1, 8'h02, 1, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_if.valid, 0);
        chk("rst_out_data",  out_if.data, 0);
        chk("rst_out_last",  out_if.last, 0);
        chk("rst_select",    select, 0);
        chk("rst_busy",      busy, 0);
        chk("rst_in1_ready", in1_if.ready, 0);
        chk("rst_in2_ready", in2_if.ready, 0);
        $display("reset: ov=%0b sel=%0b busy=%0b r1=%0b r2=%0b",
                 out_if.valid, select, busy, in1_if.ready, in2_if.ready);
        drive(0, 0, 0, 0, 0, 0, 1);
        rst_n = 1'b1;

        // ---------------------------------------------------------------------
        // Directed table: idle, round-robin tie, packet lock
        // ---------------------------------------------------------------------
        tbl[0] = mk(0, 8'h00, 0, 0, 8'h00, 0, 1,  0, 0, 0, 0,  0, 8'h00, 0);
        tbl[1] = mk(1, 8'h11, 1, 1, 8'h22, 1, 1,  1, 0, 0, 0,  1, 8'h11, 1);
        tbl[2] = mk(1, 8'h11, 1, 1, 8'h22, 1, 1,  FIXED, !FIXED, !FIXED, 0,
                    1, FIXED ? 8'h11 : 8'h22, 1);
        tbl[3] = mk(1, 8'h11, 1, 1, 8'h22, 1, 1,  1, 0, 0, 0,  1, 8'h11, 1);
        tbl[4] = mk(1, 8'h11, 1, 1, 8'h22, 1, 1,  FIXED, !FIXED, !FIXED, 0,
                    1, FIXED ? 8'h11 : 8'h22, 1);
        tbl[5] = mk(1, 8'hA0, 0, 1, 8'h33, 1, 1,  1, 0, 0, 0,  1, 8'hA0, 0);
        tbl[6] = mk(1, 8'hA1, 0, 1, 8'h33, 1, 1,  1, 0, 0, 1,  1, 8'hA1, 0);
        tbl[7] = mk(1, 8'hA2, 1, 1, 8'h33, 1, 1,  1, 0, 0, 1,  1, 8'hA2, 1);
        tbl[8] = mk(0, 8'h00, 0, 1, 8'h33, 1, 1,  0, 1, 1, 0,  1, 8'h33, 1);
        tbl[9] = mk(0, 8'h00, 0, 0, 8'h00, 0, 1,  0, 0, 1, 0,  0, 8'h00, 0);

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].v1, tbl[i].d1, tbl[i].l1, tbl[i].v2, tbl[i].d2, tbl[i].l2, tbl[i].ordy);
            #2;
            chk($sformatf("vec%0d_in1_ready", i), in1_if.ready, tbl[i].r1);
            chk($sformatf("vec%0d_in2_ready", i), in2_if.ready, tbl[i].r2);
            chk($sformatf("vec%0d_select", i),    select, tbl[i].sel);
            chk($sformatf("vec%0d_busy", i),      busy, tbl[i].bsy);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_out_valid", i), out_if.valid, tbl[i].ov);
            if (tbl[i].ov) begin
                chk($sformatf("vec%0d_out_data", i), out_if.data, tbl[i].od);
                chk($sformatf("vec%0d_out_last", i), out_if.last, tbl[i].ol);
            end
            $display("vec %0d: v1=%0b v2=%0b -> r1=%0b r2=%0b sel=%0b busy=%0b out=%0b/%0h/%0b",
                     i, tbl[i].v1, tbl[i].v2, in1_if.ready, in2_if.ready, select, busy,
                     out_if.valid, out_if.data, out_if.last);
        end

        // ---------------------------------------------------------------------
        // Backpressure: 4 stalled cycles, exactly one beat taken, then 1/cycle
        // ---------------------------------------------------------------------
        accepts = 0;
        drive(1, 8'h51, 1, 0, 8'h00, 0, 0);
        for (int c = 0; c < 4; c++) begin
            #2;
            chk($sformatf("bp_stall%0d_in1_ready", c), in1_if.ready, (c == 0));
            if (in1_if.ready && in1_if.valid) accepts++;
            @(posedge clk);
            #1;
            if (c == 0) in1_if.data = 8'h52;
            chk($sformatf("bp_stall%0d_out_valid", c), out_if.valid, 1);
            chk($sformatf("bp_stall%0d_out_data", c),  out_if.data, 8'h51);
            $display("bp stall %0d: out=%0h accepts=%0d", c, out_if.data, accepts);
        end
        chk("bp_accept_count", accepts, 1);
        out_if.ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #2;
            chk($sformatf("bp_run%0d_in1_ready", c), in1_if.ready, 1);
            @(posedge clk);
            #1;
            chk($sformatf("bp_run%0d_out_data", c), out_if.data, 8'h52 + 8'(c));
            chk($sformatf("bp_run%0d_out_valid", c), out_if.valid, 1);
            $display("bp run %0d: out=%0h", c, out_if.data);
            in1_if.data = in1_if.data + 8'h01;
        end
        drive(0, 0, 0, 0, 0, 0, 1);
        @(posedge clk);
        #1;
        chk("bp_drain_out_valid", out_if.valid, 0);

        // ---------------------------------------------------------------------
        // Reset during beat 2 of an in2 packet
        // ---------------------------------------------------------------------
        drive(0, 8'h00, 0, 1, 8'h61, 0, 1);
        #2;
        chk("rm_beat1_in2_ready", in2_if.ready, 1);
        chk("rm_beat1_select",    select, 1);
        @(posedge clk);
        #1;
        chk("rm_beat1_busy",      busy, 1);
        chk("rm_beat1_out_data",  out_if.data, 8'h61);
        in2_if.data = 8'h62;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rm_async_out_valid", out_if.valid, 0);
        chk("rm_async_busy",      busy, 0);
        chk("rm_async_out_data",  out_if.data, 0);
        chk("rm_async_in2_ready", in2_if.ready, 0);
        chk("rm_async_select",    select, 0);
        $display("reset mid-packet: ov=%0b busy=%0b", out_if.valid, busy);
        @(posedge clk);
        #1;
        drive(1, 8'h71, 1, 1, 8'h72, 1, 1);
        rst_n = 1'b1;
        #2;
        chk("rm_after_in1_ready", in1_if.ready, 1);
        chk("rm_after_in2_ready", in2_if.ready, 0);
        chk("rm_after_busy",      busy, 0);
        @(posedge clk);
        #1;
        chk("rm_after_out_data",  out_if.data, 8'h71);
        $display("after reset tie: out=%0h", out_if.data);

        // ---------------------------------------------------------------------
        // Randomized traffic against the packet-level model
        // ---------------------------------------------------------------------
        drive(0, 0, 0, 0, 0, 0, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        owner      = 0;
        last_owner = 2;
        last_sel   = 0;
        mq.delete();
        for (int r = 1; r <= 2; r++) begin
            svld[r] = 1'b0;
            sdat[r] = 8'h00;
            slst[r] = 1'b0;
            srem[r] = 0;
        end

        for (int cyc = 0; cyc < 2000; cyc++) begin
            // Sources: a beat once offered is held until taken; gaps between
            // beats (including mid-packet) are random.
            for (int r = 1; r <= 2; r++) begin
                if (!svld[r] && ($urandom_range(0, 9) < 6)) begin
                    if (srem[r] == 0) srem[r] = $urandom_range(1, 4);
                    sdat[r] = 8'($urandom);
                    slst[r] = (srem[r] == 1);
                    svld[r] = 1'b1;
                end
            end
            ordy = ($urandom_range(0, 3) != 0);
            drive(svld[1], sdat[1], slst[1], svld[2], sdat[2], slst[2], ordy);
            #2;

            space = (mq.size() == 0) || ordy;
            if (owner != 0)                 g = owner;
            else if (svld[1] && svld[2])    g = (FIXED || last_owner == 2) ? 1 : 2;
            else if (svld[1])               g = 1;
            else if (svld[2])               g = 2;
            else                            g = 0;
            e_r1 = space && (g == 1);
            e_r2 = space && (g == 2);
            acc  = (g != 0) && space && svld[g];

            chk("rnd_in1_ready", in1_if.ready, e_r1);
            chk("rnd_in2_ready", in2_if.ready, e_r2);
            chk("rnd_busy",      busy, (owner != 0));
            chk("rnd_select",    select, (owner != 0 || acc) ? (g - 1) : last_sel);

            if (ordy && (mq.size() != 0)) void'(mq.pop_front());
            if (acc) begin
                mq.push_back({slst[g], sdat[g]});
                last_sel = g - 1;
                if (slst[g]) begin
                    owner      = 0;
                    last_owner = g;
                end else begin
                    owner = g;
                end
                $display("rnd %0d: req%0d beat %0h last=%0b", cyc, g, sdat[g], slst[g]);
                svld[g] = 1'b0;
                srem[g] = srem[g] - 1;
            end

            @(posedge clk);
            #1;
            chk("rnd_out_valid", out_if.valid, (mq.size() != 0));
            if (mq.size() != 0) begin
                head = mq[0];
                chk("rnd_out_data", out_if.data, head[7:0]);
                chk("rnd_out_last", out_if.last, head[8]);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
